// File: rtl/fpu_types_pkg.sv
// Shared half-precision definitions and reduction FSM types.
package fpu_types_pkg;

   localparam int HALF_FLOAT_W   = 16;
   localparam int REDUCE_INDEX_W = 8;

   localparam logic [HALF_FLOAT_W-1:0] HALF_ZERO = 16'h0000;
   localparam logic [HALF_FLOAT_W-1:0] HALF_QNAN = 16'h7E00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } reduce_state_t;

   function automatic logic half_is_nan(input logic [HALF_FLOAT_W-1:0] v);
      return (v[14:10] == 5'h1F) && (v[9:0] != 10'h000);
   endfunction

   // Maps a half to an unsigned key whose order is the numeric order, with -0 below +0.
   function automatic logic [HALF_FLOAT_W-1:0] half_order_key(input logic [HALF_FLOAT_W-1:0] v);
      return v[15] ? ~v : (v ^ 16'h8000);
   endfunction

endpackage

// File: rtl/float_minmax_16bit.sv
// Combinational half-precision min/max: a NaN operand yields the other operand,
// two NaNs yield the canonical quiet NaN, and -0 orders below +0.
module float_minmax_16bit
   import fpu_types_pkg::*;
(
   input  logic [HALF_FLOAT_W-1:0] a,
   input  logic [HALF_FLOAT_W-1:0] b,
   input  logic                    max,
   output logic [HALF_FLOAT_W-1:0] y
);

   logic                    a_nan_s;
   logic                    b_nan_s;
   logic [HALF_FLOAT_W-1:0] a_key_s;
   logic [HALF_FLOAT_W-1:0] b_key_s;

   // Select the winning operand; equal keys keep a.
   always_comb begin
      a_nan_s = half_is_nan(a);
      b_nan_s = half_is_nan(b);
      a_key_s = half_order_key(a);
      b_key_s = half_order_key(b);
      y       = a;
      if (a_nan_s && b_nan_s) begin
         y = HALF_QNAN;
      end else if (a_nan_s) begin
         y = b;
      end else if (b_nan_s) begin
         y = a;
      end else if (max) begin
         y = (b_key_s > a_key_s) ? b : a;
      end else begin
         y = (b_key_s < a_key_s) ? b : a;
      end
   end

endmodule

// File: rtl/float_minmax_reduce_16bit.sv
// Streaming min/max reduction over a vector of half-precision elements.
// Optional winner index output enabled by macro FMINMAX_REDUCE_INDEX_EN.
module float_minmax_reduce_16bit
   import fpu_types_pkg::*;
(
   input  logic                      CLK,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [HALF_FLOAT_W-1:0]   in_data,
   input  logic                      in_last,
   input  logic                      max,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [HALF_FLOAT_W-1:0]   out_data
`ifdef FMINMAX_REDUCE_INDEX_EN
   ,
   output logic [REDUCE_INDEX_W-1:0] out_index
`endif
);

   reduce_state_t           state_r;
   logic [HALF_FLOAT_W-1:0] acc_r;
   logic                    max_r;
   logic                    out_valid_r;
   logic                    in_ready_r;
   logic [HALF_FLOAT_W-1:0] mm_s;
   logic                    xfer_s;

   assign xfer_s    = in_valid & in_ready_r;
   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = acc_r;

   float_minmax_16bit u_minmax (
      .a   (acc_r),
      .b   (in_data),
      .max (max_r),
      .y   (mm_s)
   );

`ifdef FMINMAX_REDUCE_INDEX_EN
   logic [REDUCE_INDEX_W-1:0] cnt_r;
   logic [REDUCE_INDEX_W-1:0] idx_r;
   logic                      upd_idx_s;

   assign out_index = idx_r;

   // A new winner only when the result actually moved to the incoming element.
   always_comb begin
      upd_idx_s = (mm_s == in_data) && (mm_s != acc_r);
   end
`endif

   // Reduction FSM with registered handshake outputs.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_r     <= IDLE;
         acc_r       <= HALF_ZERO;
         max_r       <= 1'b0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
`ifdef FMINMAX_REDUCE_INDEX_EN
         cnt_r       <= 8'd0;
         idx_r       <= 8'd0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (xfer_s) begin
                  acc_r <= in_data;
                  max_r <= max;
`ifdef FMINMAX_REDUCE_INDEX_EN
                  cnt_r <= 8'd1;
                  idx_r <= 8'd0;
`endif
                  if (in_last) begin
                     state_r     <= DONE;
                     out_valid_r <= 1'b1;
                     in_ready_r  <= 1'b0;
                  end else begin
                     state_r <= ACCUM;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            ACCUM: begin
               if (xfer_s) begin
                  acc_r <= mm_s;
`ifdef FMINMAX_REDUCE_INDEX_EN
                  cnt_r <= cnt_r + 8'd1;
                  if (upd_idx_s) begin
                     idx_r <= cnt_r;
                  end else begin
                     idx_r <= idx_r;
                  end
`endif
                  if (in_last) begin
                     state_r     <= DONE;
                     out_valid_r <= 1'b1;
                     in_ready_r  <= 1'b0;
                  end else begin
                     state_r <= ACCUM;
                  end
               end else begin
                  state_r <= ACCUM;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_r     <= IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
`ifdef FMINMAX_REDUCE_INDEX_EN
                  cnt_r       <= 8'd0;
`endif
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r     <= IDLE;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_float_minmax_reduce_16bit.sv
// Directed self-checking bench for float_minmax_reduce_16bit.
module tb_float_minmax_reduce_16bit;
   import fpu_types_pkg::*;

   logic                    CLK = 1'b0;
   logic                    reset = 1'b1;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [HALF_FLOAT_W-1:0] in_data = 16'h0000;
   logic                    in_last = 1'b0;
   logic                    max = 1'b0;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [HALF_FLOAT_W-1:0] out_data;
`ifdef FMINMAX_REDUCE_INDEX_EN
   logic [7:0]              out_index;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   float_minmax_reduce_16bit dut (
      .CLK       (CLK),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .max       (max),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef FMINMAX_REDUCE_INDEX_EN
      ,
      .out_index (out_index)
`endif
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idx(input string tag, input logic [7:0] exp);
`ifdef FMINMAX_REDUCE_INDEX_EN
      chk(tag, {8'h00, out_index}, {8'h00, exp});
`else
      if (exp === 8'hFF) $display("unreachable %s", tag);
`endif
   endtask

   task automatic beat(input logic [15:0] d, input logic l, input logic m);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      max      = m;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("drain_valid", {15'd0, out_valid}, 16'd0);
      chk("drain_ready", {15'd0, in_ready}, 16'd1);
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b0;
      chk("rst_valid", {15'd0, out_valid}, 16'd0);
      chk("rst_ready", {15'd0, in_ready}, 16'd1);
      chk("rst_data", out_data, 16'h0000);
      chk_idx("rst_index", 8'd0);

      // Max vector {1.0, 2.0, -1.0}
      beat(16'h3C00, 1'b0, 1'b1);
      chk("maxv_b1_valid", {15'd0, out_valid}, 16'd0);
      beat(16'h4000, 1'b0, 1'b1);
      chk("maxv_b2_valid", {15'd0, out_valid}, 16'd0);
      beat(16'hBC00, 1'b1, 1'b1);
      chk("maxv_valid", {15'd0, out_valid}, 16'd1);
      chk("maxv_ready", {15'd0, in_ready}, 16'd0);
      chk("maxv_data", out_data, 16'h4000);
      chk_idx("maxv_index", 8'd1);
      drain();

      // Min vector {0.5, -1.0, +inf}
      beat(16'h3800, 1'b0, 1'b0);
      beat(16'hBC00, 1'b0, 1'b0);
      beat(16'h7C00, 1'b1, 1'b0);
      chk("minv_valid", {15'd0, out_valid}, 16'd1);
      chk("minv_data", out_data, 16'hBC00);
      chk_idx("minv_index", 8'd1);
      drain();

      // Single NaN element
      beat(16'h7E00, 1'b1, 1'b1);
      chk("single_valid", {15'd0, out_valid}, 16'd1);
      chk("single_data", out_data, 16'h7E00);
      chk_idx("single_index", 8'd0);
      drain();

      // Signed zero: min(+0, -0) = -0
      beat(16'h0000, 1'b0, 1'b0);
      beat(16'h8000, 1'b1, 1'b0);
      chk("zero_data", out_data, 16'h8000);
      chk_idx("zero_index", 8'd1);
      drain();

      // NaN first element is displaced by a number
      beat(16'h7E00, 1'b0, 1'b1);
      beat(16'h3C00, 1'b1, 1'b1);
      chk("nan_data", out_data, 16'h3C00);
      chk_idx("nan_index", 8'd1);
      drain();

      // Backpressure: result held, DONE ignores in_valid
      beat(16'hC000, 1'b0, 1'b1);
      beat(16'h3C00, 1'b1, 1'b1);
      in_valid = 1'b1;
      in_data  = 16'h7BFF;
      in_last  = 1'b1;
      max      = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", {15'd0, out_valid}, 16'd1);
         chk("bp_data", out_data, 16'h3C00);
         chk("bp_ready", {15'd0, in_ready}, 16'd0);
         tick();
      end
      chk_idx("bp_index", 8'd1);
      in_data   = 16'h4400;
      out_ready = 1'b1;
      tick();
      chk("bp_xfer_valid", {15'd0, out_valid}, 16'd0);
      chk("bp_xfer_ready", {15'd0, in_ready}, 16'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("b2b_valid", {15'd0, out_valid}, 16'd1);
      chk("b2b_data", out_data, 16'h4400);
      chk_idx("b2b_index", 8'd0);
      tick();
      out_ready = 1'b0;
      chk("b2b_done_valid", {15'd0, out_valid}, 16'd0);

      // Reset mid-vector discards the partial result
      beat(16'h5000, 1'b0, 1'b1);
      beat(16'h5400, 1'b0, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rmid_valid", {15'd0, out_valid}, 16'd0);
         chk("rmid_ready", {15'd0, in_ready}, 16'd1);
         tick();
      end
      chk("rmid_data", out_data, 16'h0000);
      beat(16'h4000, 1'b1, 1'b1);
      chk("rmid_next_valid", {15'd0, out_valid}, 16'd1);
      chk("rmid_next_data", out_data, 16'h4000);
      drain();

      // max toggled after the first beat is ignored
      beat(16'h3C00, 1'b0, 1'b0);
      beat(16'h4000, 1'b1, 1'b1);
      chk("tog_data", out_data, 16'h3C00);
      chk_idx("tog_index", 8'd0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
